// File: rtl/missed_dose_log_reader_if.sv
// Bus bundle for missed_dose_log_reader: the RAM read port and the
// valid/ready record stream toward the LCD formatter.
// master = the log reader, slave = RAM + formatter side.
interface missed_dose_log_reader_if #(
  parameter int unsigned ADDR_W = 8
);
  // RAM read port
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden;
  logic [27:0]       ram_q;

  // record stream
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_patient;
  logic [23:0]       out_time;
  logic [ADDR_W-1:0] out_index;

  modport master (
    output ram_addr, ram_rden, out_valid, out_patient, out_time, out_index,
    input  ram_q, out_ready
  );

  modport slave (
    input  ram_addr, ram_rden, out_valid, out_patient, out_time, out_index,
    output ram_q, out_ready
  );
endinterface

// File: rtl/missed_dose_log_reader.sv
// missed_dose_log_reader: scans the missed-dose log RAM from address 0,
// skips malformed records, presents qualifying ones over valid/ready and
// counts them (saturating at 255). Stops at an END_ID slot or the last
// address.
// Optional build macro PATIENT_FILTER_EN: only records whose patient_id
// matches patient_sel (sampled at start) qualify.
module missed_dose_log_reader #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [3:0]  END_ID       = 4'hF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               patient_sel,
  missed_dose_log_reader_if.master bus,
  output logic [7:0]               miss_count,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        lat_cnt;
  logic [27:0]       rec;

  logic              last;
  logic              is_end;
  logic              digits_ok;
  logic              range_ok;
  logic              pid_ok;
  logic              qualify;

  assign last   = (ptr == ADDR_W'(DEPTH - 1));
  assign is_end = (rec[27:24] == END_ID);

`ifdef PATIENT_FILTER_EN
  logic [3:0] sel_q;
  assign pid_ok = (rec[27:24] == sel_q);
`else
  logic unused_sel;
  assign unused_sel = ^patient_sel;
  assign pid_ok     = 1'b1;
`endif

  // every BCD nibble of the captured time must be a decimal digit
  always_comb begin
    digits_ok = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (rec[i*4 +: 4] > 4'd9) digits_ok = 1'b0;
    end
  end

  // with decimal digits, HH<=23 / MM<=59 / SS<=59 reduce to tens-digit tests
  assign range_ok = ((rec[23:20] < 4'd2) || (rec[23:20] == 4'd2 && rec[19:16] <= 4'd3))
                    && (rec[15:12] <= 4'd5)
                    && (rec[7:4]   <= 4'd5);

  assign qualify = digits_ok && range_ok && pid_ok;

  // presented record fields come straight from the captured record and ptr,
  // both of which are frozen while in PRESENT
  assign bus.out_patient = rec[27:24];
  assign bus.out_time    = rec[23:0];
  assign bus.out_index   = ptr;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state decode and state-derived outputs
  always_comb begin
    state_nxt     = state;
    bus.ram_rden  = 1'b0;
    bus.ram_addr  = addr_q;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        bus.ram_rden = 1'b1;
        bus.ram_addr = ptr;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt == '0) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (is_end)       state_nxt = S_FINISH;
        else if (qualify) state_nxt = S_PRESENT;
        else if (last)    state_nxt = S_FINISH;
        else              state_nxt = S_ISSUE;
      end
      S_PRESENT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = last ? S_FINISH : S_ISSUE;
      end
      S_FINISH: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // scan datapath: pointer, address hold, latency count, record capture, count
  // The counter is loaded with READ_LATENCY and the capture happens on the
  // cycle it reads zero, so WAIT spans READ_LATENCY+1 cycles; together with
  // ISSUE and CHECK a skipped record costs READ_LATENCY+3 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      addr_q     <= '0;
      lat_cnt    <= '0;
      rec        <= '0;
      miss_count <= '0;
`ifdef PATIENT_FILTER_EN
      sel_q      <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            miss_count <= '0;
            ptr        <= '0;
`ifdef PATIENT_FILTER_EN
            sel_q      <= patient_sel;
`endif
          end
        end
        S_ISSUE: begin
          addr_q  <= ptr;
          lat_cnt <= 2'(READ_LATENCY);
        end
        S_WAIT: begin
          if (lat_cnt == '0) rec <= bus.ram_q;
          else               lat_cnt <= lat_cnt - 2'd1;
        end
        S_CHECK: begin
          if (!is_end && !qualify && !last) ptr <= ptr + 1'b1;
        end
        S_PRESENT: begin
          if (bus.out_ready) begin
            if (miss_count != '1) miss_count <= miss_count + 8'd1;
            if (!last)            ptr        <= ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/missed_dose_log_reader.md
Name: missed_dose_log_reader

Overview:
- Read side of the missed-dose log RAM: the pill-taken recorder writes 28-bit records into this RAM; this block scans it back for the "missed" LCD scene.
- On a start pulse it walks the RAM from address 0 and presents each qualifying record to the LCD formatter over a valid/ready handshake.
- Counts the missed doses it presents and stops at the end marker or at the last address.

Parameters:
- ADDR_W, 8, RAM address width.
- DEPTH, 256, number of log entries scanned; last address is DEPTH-1.
- READ_LATENCY, 1, cycles from ram_rden/ram_addr to valid ram_q (1..3).
- END_ID, 4'hF, patient_id value that marks an empty slot or end of log.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- start, input, 1, one-cycle pulse that begins a scan; ignored while busy.
- patient_sel, input, 4, patient filter (used only with PATIENT_FILTER_EN).
- ram_addr, output, ADDR_W, RAM read address.
- ram_rden, output, 1, RAM read strobe; one cycle per read.
- ram_q, input, 28, RAM read data: [27:24] patient_id; [23:0] scheduled time as BCD HHMMSS.
- out_valid, output, 1, a record is presented.
- out_ready, input, 1, the LCD formatter accepts the record.
- out_patient, output, 4, patient_id of the presented record.
- out_time, output, 24, BCD time of the presented record.
- out_index, output, ADDR_W, RAM address of the presented record.
- miss_count, output, 8, records presented in the current or last scan; saturates at 255.
- busy, output, 1, a scan is in progress.
- done, output, 1, one-cycle pulse when a scan finishes.

Behaviour:
- Reset (async, active-high):
  - Outputs: all outputs 0.
  - Internal: ptr = 0, FSM = IDLE, latency counter cleared.
  - Reset mid-scan aborts immediately. No done pulse is produced.
- FSM states: IDLE, ISSUE, WAIT, CHECK, PRESENT, FINISH.
- IDLE: on start, clear miss_count, set ptr = 0, set busy = 1, go to ISSUE.
- ISSUE: drive ram_addr = ptr and ram_rden = 1 for exactly one cycle. Load the latency counter. Go to WAIT.
- WAIT: stay READ_LATENCY cycles, then capture ram_q into an internal record register. Go to CHECK.
- CHECK: evaluate the captured record in one cycle.
  - patient_id == END_ID: go to FINISH.
  - Any BCD digit > 9, or HH > 23, MM > 59 or SS > 59: the record is malformed. Skip it; it is not counted.
  - Otherwise the record qualifies: go to PRESENT.
  - On a skip: if ptr == DEPTH-1 go to FINISH; else ptr++ and go to ISSUE.
- PRESENT:
  - out_valid = 1. out_patient, out_time and out_index are stable while out_valid is 1.
  - On out_valid && out_ready: increment miss_count (saturating at 255), drop out_valid the next cycle.
  - After the transfer: if ptr == DEPTH-1 go to FINISH; else ptr++ and go to ISSUE.
  - out_ready held low stalls indefinitely; there is no timeout.
  - If out_ready is high on the first PRESENT cycle, out_valid is high for exactly one cycle.
- FINISH: done = 1 for one cycle, busy = 0 the same cycle, go to IDLE. miss_count holds until the next start.
- Start arriving in any state other than IDLE is ignored. Start and done in the same cycle: start is ignored.
- Throughput: READ_LATENCY+3 cycles per skipped record, plus the handshake cycles for each presented record.
- At most one outstanding RAM read. ram_addr holds its last value when ram_rden = 0.

Optional Feature:
- Macro PATIENT_FILTER_EN.
- Defined: a record qualifies only if patient_id == patient_sel. patient_sel is sampled into a register on start and held for the whole scan. Non-matching valid records are skipped and not counted.
- Undefined: patient_sel is ignored; every well-formed, non-END_ID record is presented.

Test Plan:
- RAM[0]={1,24'h083000}, RAM[1]={2,24'h120000}, RAM[2]={F,...}; start; out_ready=1 -> two transfers, (1,083000,idx 0) then (2,120000,idx 1); done pulses; miss_count=2; ram_rden never asserted for addr 3.
- Same RAM; out_ready low for 10 cycles on the first record -> out_valid held, data stable, ram_rden low during the stall; completes with miss_count=2.
- RAM[0]={3,24'h256000} (bad hour), RAM[1]={3,24'h091500}, RAM[2]=END -> only idx 1 presented; miss_count=1.
- All 256 entries valid patient 4, out_ready=1 -> 256 transfers, miss_count=255 (saturated), done after address 255, no wrap to 0.
- With PATIENT_FILTER_EN, patient_sel=2, RAM {1,..},{2,..},{2,..},END -> idx 1 and 2 presented, miss_count=2. Changing patient_sel mid-scan has no effect.
- Assert reset while in PRESENT -> out_valid, busy, miss_count = 0 asynchronously; no done pulse; start pulse while busy (separate run) -> ignored, scan unaffected.
